// File: rtl/bldc_pkg.sv
// Shared BLDC definitions: hall code map, direction encoding and sector helpers.
// Intended for reuse by the hall emulator and by CommutationControl benches.
package bldc_pkg;

  localparam logic [2:0] HALL_S1 = 3'b100;
  localparam logic [2:0] HALL_S2 = 3'b110;
  localparam logic [2:0] HALL_S3 = 3'b010;
  localparam logic [2:0] HALL_S4 = 3'b011;
  localparam logic [2:0] HALL_S5 = 3'b001;
  localparam logic [2:0] HALL_S6 = 3'b101;

  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_CCW = 1'b1;

  localparam logic [2:0] SECTOR_FIRST = 3'd1;
  localparam logic [2:0] SECTOR_LAST  = 3'd6;

  typedef enum logic [1:0] {
    FAULT_IDLE    = 2'd0,
    FAULT_PENDING = 2'd1,
    FAULT_ACTIVE  = 2'd2
  } fault_state_t;

  // Sectors outside 1..6 map to 000 so a corrupted position reads as a fault code.
  function automatic logic [2:0] sector_to_hall(input logic [2:0] sector);
    logic [2:0] code;
    case (sector)
      3'd1:    code = HALL_S1;
      3'd2:    code = HALL_S2;
      3'd3:    code = HALL_S3;
      3'd4:    code = HALL_S4;
      3'd5:    code = HALL_S5;
      3'd6:    code = HALL_S6;
      default: code = 3'b000;
    endcase
    return code;
  endfunction

  function automatic logic [2:0] sector_advance(input logic [2:0] sector, input logic dir_ccw);
    logic [2:0] next_sector;
    if (dir_ccw == DIR_CCW) begin
      next_sector = (sector == SECTOR_LAST) ? SECTOR_FIRST : sector + 3'd1;
    end else begin
      next_sector = (sector == SECTOR_FIRST) ? SECTOR_LAST : sector - 3'd1;
    end
    return next_sector;
  endfunction

endpackage

// File: rtl/hall_sensor_emulator_if.sv
// Control and output bundle of the hall sensor emulator.
// master drives rotor controls and observes hall outputs; slave is the emulator.
interface hall_sensor_emulator_if #(
  parameter int PERIOD_W = 16,
  parameter int REV_W    = 8
);

  logic                enable;
  logic                dir_ccw;
  logic [PERIOD_W-1:0] step_period;
  logic                fault_req;

  logic [2:0]          hall_sensor;
  logic [2:0]          sector;
  logic                step_pulse;
  logic                fault_active;
  logic [REV_W-1:0]    rev_count;

  modport master (
    output enable, dir_ccw, step_period, fault_req,
    input  hall_sensor, sector, step_pulse, fault_active, rev_count
  );

  modport slave (
    input  enable, dir_ccw, step_period, fault_req,
    output hall_sensor, sector, step_pulse, fault_active, rev_count
  );

endinterface

// File: rtl/hall_step_timer.sv
// Step-rate timer: latches period and direction at enable rise and at every step,
// and emits a single-cycle step tick every latched-period cycles while enabled.
module hall_step_timer
  import bldc_pkg::*;
#(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_enable,
  input  logic                i_dir_ccw,
  input  logic [PERIOD_W-1:0] i_step_period,
  output logic                o_step,
  output logic                o_dir_ccw
);

  localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(2);

  logic                r_enable_d;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_timer;
  logic                r_dir_ccw;

  logic                w_rise;
  logic                w_step;
  logic [PERIOD_W-1:0] w_period_clamped;

  assign w_rise           = i_enable & ~r_enable_d;
  assign w_period_clamped = (i_step_period < MIN_PERIOD) ? MIN_PERIOD : i_step_period;

  // r_period never drops below 2, so the rising-edge cycle (timer 0) cannot also be a step.
  assign w_step = i_enable & (r_timer == (r_period - PERIOD_W'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_enable_d <= 1'b0;
      r_period   <= MIN_PERIOD;
      r_timer    <= '0;
      r_dir_ccw  <= DIR_CCW;
    end else begin
      r_enable_d <= i_enable;

      if (!i_enable || w_step) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + PERIOD_W'(1);
      end

      // The step consumes the old period/direction; the new sample governs the next one.
      if (w_rise || w_step) begin
        r_period  <= w_period_clamped;
        r_dir_ccw <= i_dir_ccw;
      end
    end
  end

  assign o_step    = w_step;
  assign o_dir_ccw = r_dir_ccw;

endmodule

// File: rtl/hall_sensor_emulator.sv
// Virtual rotor: steps the six-sector hall sequence from the step timer, counts
// electrical revolutions and can substitute one step with an invalid hall code.
module hall_sensor_emulator
  import bldc_pkg::*;
#(
  parameter int         PERIOD_W   = 16,
  parameter int         REV_W      = 8,
  parameter logic [2:0] FAULT_CODE = 3'b000
) (
  input  logic                   clk,
  input  logic                   reset,
  hall_sensor_emulator_if.slave  bus
);

  logic             w_step;
  logic             w_dir_ccw;
  logic [2:0]       w_pos_next;
  logic             w_rev_up;
  logic             w_rev_down;

  fault_state_t     r_fault_state;
  logic [2:0]       r_pos;
  logic [2:0]       r_hall;
  logic [2:0]       r_sector;
  logic             r_step_pulse;
  logic             r_fault_active;
  logic [REV_W-1:0] r_rev;

  hall_step_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk           (clk),
    .reset         (reset),
    .i_enable      (bus.enable),
    .i_dir_ccw     (bus.dir_ccw),
    .i_step_period (bus.step_period),
    .o_step        (w_step),
    .o_dir_ccw     (w_dir_ccw)
  );

  assign w_pos_next = sector_advance(r_pos, w_dir_ccw);
  assign w_rev_up   = (w_dir_ccw == DIR_CCW) && (r_pos == SECTOR_LAST);
  assign w_rev_down = (w_dir_ccw == DIR_CW)  && (r_pos == SECTOR_FIRST);

  // Position keeps advancing through a fault step; only the displayed code is replaced.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fault_state  <= FAULT_IDLE;
      r_pos          <= SECTOR_FIRST;
      r_hall         <= HALL_S1;
      r_sector       <= SECTOR_FIRST;
      r_step_pulse   <= 1'b0;
      r_fault_active <= 1'b0;
      r_rev          <= '0;
    end else begin
      r_step_pulse <= w_step;

      case (r_fault_state)
        FAULT_IDLE: begin
          if (bus.fault_req) begin
            r_fault_state <= FAULT_PENDING;
          end
        end
        FAULT_PENDING: begin
          if (w_step) begin
            r_fault_state <= FAULT_ACTIVE;
          end
        end
        FAULT_ACTIVE: begin
          if (w_step) begin
            r_fault_state <= FAULT_IDLE;
          end
        end
        default: begin
          r_fault_state <= FAULT_IDLE;
        end
      endcase

      if (w_step) begin
        r_pos <= w_pos_next;

        if (w_rev_up) begin
          r_rev <= r_rev + REV_W'(1);
        end else if (w_rev_down) begin
          r_rev <= r_rev - REV_W'(1);
        end

        if (r_fault_state == FAULT_PENDING) begin
          r_hall         <= FAULT_CODE;
          r_sector       <= 3'd0;
          r_fault_active <= 1'b1;
        end else begin
          r_hall         <= sector_to_hall(w_pos_next);
          r_sector       <= w_pos_next;
          r_fault_active <= 1'b0;
        end
      end
    end
  end

  assign bus.hall_sensor  = r_hall;
  assign bus.sector       = r_sector;
  assign bus.step_pulse   = r_step_pulse;
  assign bus.fault_active = r_fault_active;
  assign bus.rev_count    = r_rev;

endmodule

// File: tb/tb_hall_sensor_emulator.sv
// Scoreboard bench for hall_sensor_emulator: a deadline-based rotor model predicts
// every step; a monitor checks each step_pulse against the predicted step.
module tb_hall_sensor_emulator;

  localparam int PERIOD_W = 16;
  localparam int REV_W    = 8;

  typedef struct {
    int         edge_no;
    logic [2:0] hall;
    logic [2:0] sector;
    logic       fault;
    logic [7:0] rev;
  } exp_t;

  logic clk;
  logic reset;
  int   edge_n;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  // model state: position index 0..5 (sector-1), fault 0=none 1=pending 2=active
  logic [2:0] hall_tab [6];
  bit         m_run;
  int         m_pos;
  int         m_fault;
  int         m_rev;
  int         m_per;
  bit         m_dir;
  int         m_deadline;

  hall_sensor_emulator_if #(.PERIOD_W(PERIOD_W), .REV_W(REV_W)) bus ();

  hall_sensor_emulator #(
    .PERIOD_W   (PERIOD_W),
    .REV_W      (REV_W),
    .FAULT_CODE (3'b000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s edge %0d actual %0h required %0h", name, edge_n, act, req);
    end
  endtask

  function automatic int clamp_period(input logic [PERIOD_W-1:0] sp);
    return (sp < 2) ? 2 : int'(sp);
  endfunction

  // Predict what the edge numbered e does with the given inputs.
  task automatic model_edge(input int e, input bit r, input bit en, input bit dir,
                            input logic [PERIOD_W-1:0] sp, input bit fr);
    bit   accept;
    bit   show_fault;
    exp_t x;
    if (r) begin
      m_run = 0; m_pos = 0; m_fault = 0; m_rev = 0;
      return;
    end
    accept = fr && (m_fault == 0);
    if (!en) begin
      m_run = 0;
    end else if (!m_run) begin
      m_run = 1;
      m_per = clamp_period(sp);
      m_dir = dir;
      m_deadline = e + m_per - 1;
    end else if (e == m_deadline) begin
      if (m_dir) begin
        if (m_pos == 5) m_rev++;
        m_pos = (m_pos + 1) % 6;
      end else begin
        if (m_pos == 0) m_rev--;
        m_pos = (m_pos + 5) % 6;
      end
      show_fault = (m_fault == 1);
      m_fault    = show_fault ? 2 : 0;
      x.edge_no  = e;
      x.hall     = show_fault ? 3'b000 : hall_tab[m_pos];
      x.sector   = show_fault ? 3'd0 : 3'(m_pos + 1);
      x.fault    = show_fault;
      x.rev      = 8'(m_rev);
      exp_q.push_back(x);
      m_per      = clamp_period(sp);
      m_dir      = dir;
      m_deadline = e + m_per;
    end
    if (accept) m_fault = 1;
  endtask

  task automatic drive(input bit r, input bit en, input bit dir,
                       input logic [PERIOD_W-1:0] sp, input bit fr);
    @(negedge clk);
    reset           = r;
    bus.enable      = en;
    bus.dir_ccw     = dir;
    bus.step_period = sp;
    bus.fault_req   = fr;
    model_edge(edge_n + 1, r, en, dir, sp, fr);
  endtask

  task automatic run(input int n, input bit en, input bit dir, input logic [PERIOD_W-1:0] sp);
    for (int i = 0; i < n; i++) drive(0, en, dir, sp, 0);
  endtask

  task automatic apply_reset(input bit fr);
    drive(1, 0, 1, 3, fr);
    drive(1, 0, 1, 3, fr);
    @(posedge clk);
    #1;
    chk("rst_hall", 32'(bus.hall_sensor), 32'h4);
    chk("rst_sector", 32'(bus.sector), 32'd1);
    chk("rst_pulse", 32'(bus.step_pulse), 32'd0);
    chk("rst_fault", 32'(bus.fault_active), 32'd0);
    chk("rst_rev", 32'(bus.rev_count), 32'd0);
  endtask

  // Monitor: one step_pulse per predicted step, at the predicted edge, with predicted outputs.
  initial begin
    exp_t x;
    bit   due;
    forever begin
      @(posedge clk);
      #1;
      due = (exp_q.size() > 0) && (exp_q[0].edge_no == edge_n);
      if (due || bus.step_pulse === 1'b1) begin
        chk("step_pulse", 32'(bus.step_pulse), 32'(due));
      end
      if (due) begin
        x = exp_q.pop_front();
        chk("hall", 32'(bus.hall_sensor), 32'(x.hall));
        chk("sector", 32'(bus.sector), 32'(x.sector));
        chk("fault_active", 32'(bus.fault_active), 32'(x.fault));
        chk("rev_count", 32'(bus.rev_count), 32'(x.rev));
        $display("step edge %0d hall %b sector %0d fault %0d rev %0d",
                 edge_n, bus.hall_sensor, bus.sector, bus.fault_active, $signed(bus.rev_count));
      end else if (exp_q.size() > 0 && exp_q[0].edge_no < edge_n) begin
        x = exp_q.pop_front();
        chk("stale_step", 32'(x.edge_no), 32'(edge_n));
      end
    end
  end

  initial begin
    bit                  en;
    bit                  dir;
    logic [PERIOD_W-1:0] sp;
    hall_tab = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
    checks = 0; errors = 0;
    m_run = 0; m_pos = 0; m_fault = 0; m_rev = 0; m_per = 2; m_dir = 1; m_deadline = 0;
    reset = 1'b1;
    bus.enable = 1'b0; bus.dir_ccw = 1'b1; bus.step_period = 3; bus.fault_req = 1'b0;

    // CCW full revolution at period 3
    apply_reset(0);
    run(22, 1, 1, 3);

    // CW full revolution at period 4
    apply_reset(0);
    run(28, 1, 0, 4);

    // clamped periods, then 3 -> 5 mid-step
    apply_reset(0);
    run(8, 1, 1, 0);
    run(8, 1, 1, 1);
    run(4, 0, 1, 3);
    run(2, 1, 1, 3);
    run(16, 1, 1, 5);

    // fault at sector 2, second request while active is ignored
    apply_reset(0);
    for (int i = 0; i < 40 && m_pos != 1; i++) drive(0, 1, 1, 3, 0);
    drive(0, 1, 1, 3, 1);
    for (int i = 0; i < 40 && m_fault != 2; i++) drive(0, 1, 1, 3, 0);
    drive(0, 1, 1, 3, 1);
    run(10, 1, 1, 3);

    // enable drop mid-step
    run(4, 1, 1, 3);
    run(10, 0, 1, 3);
    run(10, 1, 1, 3);

    // enable drop during a fault step, then reset during a fault step with fault_req
    drive(0, 1, 1, 3, 1);
    for (int i = 0; i < 40 && m_fault != 2; i++) drive(0, 1, 1, 3, 0);
    run(8, 0, 1, 3);
    run(8, 1, 1, 3);
    drive(0, 1, 1, 3, 1);
    for (int i = 0; i < 40 && m_fault != 2; i++) drive(0, 1, 1, 3, 0);
    apply_reset(1);
    run(12, 1, 1, 3);

    // randomized stretch
    en = 1; dir = 1; sp = 3;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 29) == 0) dir = ~dir;
      if ($urandom_range(0, 24) == 0) sp = PERIOD_W'($urandom_range(0, 6));
      if ($urandom_range(0, 249) == 0) apply_reset($urandom_range(0, 1) == 1);
      else drive(0, en, dir, sp, $urandom_range(0, 19) == 0);
    end

    run(4, 0, 1, 3);
    @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
